// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM encoding, the command record, bus widths and the default read latency.
package mem_arb_pkg;

  localparam int ADDR_W         = 16;
  localparam int DATA_W         = 16;
  localparam int RD_LAT_DEFAULT = 1;
  localparam int LAT_CNT_W      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RWAIT = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic              port;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker.
// On a tie, the requester that was not granted last wins; the grant is one-hot or zero.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto a single asynchronous-style SRAM port with
// registered strobes; one transaction is in flight at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  input  logic              req0_we,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  output logic              wren_n,
  output logic              oen_n,
  output arb_state_t        fsm_state
);

  // Handshake: a command transfers on the rising edge where reqN_valid and
  // reqN_ready are both high; the requester holds valid/we/addr/wdata until then.
  // rspN_valid is a single-cycle pulse with no back-pressure.

  arb_state_t             state;
  logic                   last_grant;
  logic [1:0]             grant;
  logic                   cur_we;
  logic                   cur_port;
  logic [LAT_CNT_W-1:0]   wait_cnt;
  cmd_t                   sel_cmd;
  logic                   can_accept;

  rr_arb2 u_rr (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign can_accept = (state == IDLE) && rst_n;
  assign req0_ready = can_accept && grant[0];
  assign req1_ready = can_accept && grant[1];
  assign fsm_state  = state;

  always_comb begin
    sel_cmd = '{we: req0_we, port: 1'b0, addr: req0_addr, wdata: req0_wdata};
    if (grant[1]) begin
      sel_cmd = '{we: req1_we, port: 1'b1, addr: req1_addr, wdata: req1_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      address    <= '0;
      data_out   <= '0;
      wren_n     <= 1'b1;
      oen_n      <= 1'b1;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
      last_grant <= 1'b1;
      cur_we     <= 1'b0;
      cur_port   <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            cur_we     <= sel_cmd.we;
            cur_port   <= sel_cmd.port;
            last_grant <= sel_cmd.port;
            address    <= sel_cmd.addr;
            data_out   <= sel_cmd.wdata;
            wren_n     <= ~sel_cmd.we;
            oen_n      <= sel_cmd.we;
            state      <= CMD;
          end
        end
        CMD: begin
          if (cur_we) begin
            wren_n <= 1'b1;
            state  <= IDLE;
          end else begin
            // RWAIT spans exactly RD_LAT cycles; data is sampled in its last one.
            wait_cnt <= LAT_CNT_W'(RD_LAT - 1);
            state    <= RWAIT;
          end
        end
        RWAIT: begin
          if (wait_cnt == '0) begin
            oen_n <= 1'b1;
            state <= IDLE;
            if (cur_port) begin
              rsp1_valid <= 1'b1;
              rsp1_data  <= data_in;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_data  <= data_in;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RD_LAT 1 and 3), each with a memory
// device model and a cycle-level reference model built from the arbitration rules.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_init(input logic [15:0] a);
    logic [15:0] t;
    t = a * 16'h9E37;
    return t ^ 16'h3C3C;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_inst
    localparam int LAT = (g == 0) ? 1 : 3;

    logic        rst_n;
    logic        req0_valid, req1_valid, req0_we, req1_we;
    logic [15:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [15:0] rsp0_data, rsp1_data, address, data_out, data_in;
    logic        wren_n, oen_n;
    arb_state_t  fsm_state;

    mem_arbiter #(.RD_LAT(LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req1_valid (req1_valid),
      .req0_we    (req0_we),
      .req1_we    (req1_we),
      .req0_addr  (req0_addr),
      .req1_addr  (req1_addr),
      .req0_wdata (req0_wdata),
      .req1_wdata (req1_wdata),
      .req0_ready (req0_ready),
      .req1_ready (req1_ready),
      .rsp0_valid (rsp0_valid),
      .rsp1_valid (rsp1_valid),
      .rsp0_data  (rsp0_data),
      .rsp1_data  (rsp1_data),
      .address    (address),
      .data_out   (data_out),
      .data_in    (data_in),
      .wren_n     (wren_n),
      .oen_n      (oen_n),
      .fsm_state  (fsm_state)
    );

    function automatic string tg(input string s);
      return $sformatf("L%0d %s", LAT, s);
    endfunction

    // ---------------- memory device: data valid only LAT cycles after oen_n falls
    logic [15:0] phys_mem [0:65535];
    int          rd_run = 0;
    logic        m_live = 1'b0;

    initial begin
      for (int a = 0; a < 65536; a++) phys_mem[a] = mem_init(16'(a));
    end

    always @(posedge clk) begin
      if (m_live && wren_n === 1'b0) phys_mem[address] <= data_out;
      rd_run <= (oen_n === 1'b0) ? rd_run + 1 : 0;
    end

    always_comb begin
      data_in = ~phys_mem[address];
      if (oen_n === 1'b0 && rd_run == LAT) data_in = phys_mem[address];
    end

    // ---------------- reference model and scoreboard
    int          m_cyc = 0, m_free = 0, m_acc = 0;
    logic        m_lg, m_act, m_we;
    logic [15:0] m_addr, m_dout, m_rsp0, m_rsp1;
    logic [15:0] ref_mem [int];
    logic [15:0] exp_q0[$], exp_q1[$];
    int          due_q0[$], due_q1[$];
    int          n_rsp0 = 0, n_rsp1 = 0;

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return mem_init(a);
    endfunction

    task automatic model_reset();
      m_live = 1'b1;
      m_lg   = 1'b1;
      m_act  = 1'b0;
      m_we   = 1'b0;
      m_addr = '0;
      m_dout = '0;
      m_rsp0 = '0;
      m_rsp1 = '0;
      m_free = m_cyc + 1;
      exp_q0.delete(); exp_q1.delete();
      due_q0.delete(); due_q1.delete();
    endtask

    always @(negedge clk) begin
      logic [1:0]  vld, exp_rdy;
      logic        exp_w, exp_o, ev0, ev1, p;
      logic [15:0] a;
      m_cyc++;
      if (rsp0_valid === 1'b1) n_rsp0++;
      if (rsp1_valid === 1'b1) n_rsp1++;
      if (m_live) begin
        vld     = {req1_valid, req0_valid};
        exp_rdy = 2'b00;
        if (rst_n && m_cyc >= m_free && vld != 2'b00)
          exp_rdy = (vld == 2'b11) ? (m_lg ? 2'b01 : 2'b10) : vld;
        check(tg("ready"), {30'd0, req1_ready, req0_ready}, {30'd0, exp_rdy});
        exp_w = !(m_act && m_we && m_cyc == m_acc + 1);
        exp_o = !(m_act && !m_we && m_cyc >= m_acc + 1 && m_cyc <= m_acc + 1 + LAT);
        check(tg("wren_n"), 32'(wren_n), 32'(exp_w));
        check(tg("oen_n"), 32'(oen_n), 32'(exp_o));
        check(tg("strobe_excl"), 32'(wren_n | oen_n), 32'd1);
        check(tg("address"), 32'(address), 32'(m_addr));
        check(tg("data_out"), 32'(data_out), 32'(m_dout));
        ev0 = (due_q0.size() > 0) && (due_q0[0] == m_cyc);
        ev1 = (due_q1.size() > 0) && (due_q1[0] == m_cyc);
        if (ev0) begin m_rsp0 = exp_q0.pop_front(); void'(due_q0.pop_front()); end
        if (ev1) begin m_rsp1 = exp_q1.pop_front(); void'(due_q1.pop_front()); end
        check(tg("rsp0_valid"), 32'(rsp0_valid), 32'(ev0));
        check(tg("rsp1_valid"), 32'(rsp1_valid), 32'(ev1));
        check(tg("rsp0_data"), 32'(rsp0_data), 32'(m_rsp0));
        check(tg("rsp1_data"), 32'(rsp1_data), 32'(m_rsp1));
        if (!rst_n) begin
          model_reset();
        end else if (exp_rdy != 2'b00) begin
          p      = exp_rdy[1];
          m_lg   = p;
          m_act  = 1'b1;
          m_acc  = m_cyc;
          m_we   = p ? req1_we : req0_we;
          a      = p ? req1_addr : req0_addr;
          m_addr = a;
          m_dout = p ? req1_wdata : req0_wdata;
          if (m_we) begin
            ref_mem[int'(a)] = m_dout;
            m_free = m_cyc + 2;
          end else begin
            if (p) begin exp_q1.push_back(ref_rd(a)); due_q1.push_back(m_cyc + 2 + LAT); end
            else   begin exp_q0.push_back(ref_rd(a)); due_q0.push_back(m_cyc + 2 + LAT); end
            m_free = m_cyc + 2 + LAT;
          end
        end
      end else if (rst_n === 1'b0) begin
        model_reset();
      end
    end

    // ---------------- requester drivers
    task automatic issue(input logic p, input logic we, input logic [15:0] a, input logic [15:0] d);
      bit got = 1'b0;
      if (p) begin req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d; end
      else   begin req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d; end
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk);
        got = p ? req1_ready : req0_ready;
        @(posedge clk); #1;
      end
      if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
      check(tg("req_accepted"), 32'(got), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rand_traffic(input logic p, input int n);
      for (int i = 0; i < n; i++) begin
        int gap = $urandom_range(0, 3);
        idle_cycles(gap);
        issue(p, 1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 7)), 16'($urandom));
      end
    endtask

    initial begin
      int b0, b1;
      bit got;
      rst_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0; req0_we = 1'b0; req1_we = 1'b0;
      req0_addr = '0; req1_addr = '0; req0_wdata = '0; req1_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // directed write-then-read on each port
      issue(1'b0, 1'b1, 16'h0010, 16'hBEEF);
      issue(1'b0, 1'b0, 16'h0010, 16'h0000);
      issue(1'b1, 1'b1, 16'h1234, 16'h5A5A);
      issue(1'b1, 1'b0, 16'h1234, 16'h0000);
      idle_cycles(LAT + 4);
      check(tg("rsp0_beef"), 32'(rsp0_data), 32'h0000BEEF);
      check(tg("rsp1_5a5a"), 32'(rsp1_data), 32'h00005A5A);

      // fresh reset, then a same-cycle tie
      rst_n = 1'b0; idle_cycles(1); rst_n = 1'b1;
      fork
        issue(1'b0, 1'b0, 16'h0020, 16'h0000);
        issue(1'b1, 1'b0, 16'h0030, 16'h0000);
      join
      idle_cycles(LAT + 4);

      // continuous contention: 10 reads per port
      b0 = n_rsp0; b1 = n_rsp1;
      fork
        for (int i = 0; i < 10; i++) issue(1'b0, 1'b0, 16'h0010 + 16'(i), 16'h0000);
        for (int i = 0; i < 10; i++) issue(1'b1, 1'b0, 16'h1230 + 16'(i), 16'h0000);
      join
      idle_cycles(LAT + 4);
      check(tg("contend_rsp0"), 32'(n_rsp0 - b0), 32'd10);
      check(tg("contend_rsp1"), 32'(n_rsp1 - b1), 32'd10);

      // randomized mixed traffic on a small address window
      fork
        rand_traffic(1'b0, 30);
        rand_traffic(1'b1, 30);
      join
      idle_cycles(LAT + 4);

      // reset while a read sits in RWAIT
      b1 = n_rsp1;
      issue(1'b1, 1'b0, 16'h0040, 16'h0000);
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
        if (fsm_state == RWAIT) got = 1'b1;
        else idle_cycles(1);
      end
      check(tg("reach_rwait"), 32'(got), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check(tg("oen_after_rst"), 32'(oen_n), 32'd1);
      @(posedge clk); #1;
      idle_cycles(LAT + 4);
      check(tg("aborted_no_rsp"), 32'(n_rsp1 - b1), 32'd0);
      fork
        issue(1'b0, 1'b0, 16'h0050, 16'h0000);
        issue(1'b1, 1'b0, 16'h0060, 16'h0000);
      join
      idle_cycles(LAT + 6);
      done_cnt++;
    end
  end

  initial begin
    for (int i = 0; i < 30000 && done_cnt < 2; i++) @(posedge clk);
    check("all_done", 32'(done_cnt), 32'd2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RD_LAT, default 1, meaning memory read latency in cycles from oen_n low to valid data_in (legal 1..3).
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1 each  requester has a command.
REQ-005 SHALL have ports req0_we/req1_we  input  1 each  1=write, 0=read.
REQ-006 SHALL have ports req0_addr/req1_addr  input  16 each  word address.
REQ-007 SHALL have ports req0_wdata/req1_wdata  input  16 each  write data.
REQ-008 SHALL have ports req0_ready/req1_ready  output  1 each  command accepted this cycle.
REQ-009 SHALL have ports rsp0_valid/rsp1_valid  output  1 each  one-cycle read-data pulse.
REQ-010 SHALL have ports rsp0_data/rsp1_data  output  16 each  read data, valid with rspN_valid.
REQ-011 SHALL have port address  output  16  memory address, registered.
REQ-012 SHALL have port data_out  output  16  memory write data, registered.
REQ-013 SHALL have port data_in  input  16  memory read data.
REQ-014 SHALL have port wren_n  output  1  memory write enable, active-low, registered.
REQ-015 SHALL have port oen_n  output  1  memory output enable, active-low, registered.

Function
REQ-016 SHALL implement FSM states IDLE, CMD, RWAIT; one transaction outstanding at a time.
REQ-017 In IDLE, with exactly one reqN_valid high, SHALL assert that reqN_ready combinationally and move to CMD.
REQ-018 In IDLE with both valid, SHALL grant the port not granted last (round-robin); last_grant updates on each accept.
REQ-019 reqN_ready SHALL be high only in IDLE and for at most one port per cycle.
REQ-020 On accept (cycle T), SHALL register addr/wdata/we/port; during T+1 (CMD) address/data_out SHALL hold them, wren_n=0 for write, oen_n=0 for read.
REQ-021 Write: SHALL return CMD->IDLE, wren_n=1 at T+2; no response pulse; next accept possible at T+2.
REQ-022 Read: SHALL go CMD->RWAIT, hold oen_n=0 and address stable, count RD_LAT cycles, capture data_in at end of cycle T+1+RD_LAT.
REQ-023 Read response SHALL be rspN_valid=1 for exactly cycle T+2+RD_LAT on the granted port only, FSM in IDLE that same cycle (new accept allowed).
REQ-024 wren_n and oen_n SHALL never be low simultaneously; both high in IDLE.
REQ-025 address and data_out SHALL hold last value when idle.
REQ-026 rspN_data SHALL hold last captured value between pulses.
REQ-027 Requester contract: valid, we, addr, wdata stable until ready; arbiter need not tolerate violation.
REQ-028 Continuous contention SHALL alternate grants 0,1,0,1...; no port starves beyond one transaction.

Reset
REQ-029 On rst_n=0 at a clk edge: state=IDLE, address=0, data_out=0, wren_n=1, oen_n=1, readies=0, rsp valid=0, rsp data=0, last_grant=1 (port 0 wins first tie).
REQ-030 Reset mid-transaction SHALL abort it: no response pulse, memory strobes high next cycle.
REQ-031 No reqN_ready SHALL assert while rst_n=0.

Structure
REQ-032 Shared package mem_arb_pkg SHALL hold the state encoding, default RD_LAT, and 16-bit width constants.
REQ-033 Round-robin pick SHALL be sub-module rr_arb2 (two requests, last_grant in, one-hot grant out); FSM/datapath in mem_arbiter.

Verification
REQ-034 Port 0 write 0x0010<=0xBEEF, then read 0x0010 (RD_LAT=1): wren_n low exactly one cycle; rsp0_valid at accept+3 with 0xBEEF.
REQ-035 Both valid in same IDLE cycle after reset: port 0 granted first, port 1 next accept; rsp order 0 then 1.
REQ-036 Both requesters continuously issue reads for 20 transactions: grants strictly alternate, 10 each, no rsp on wrong port.
REQ-037 RD_LAT=3, port 1 reads 0x1234 holding 0x5A5A: oen_n low 4 cycles, rsp1_valid at accept+5 with 0x5A5A.
REQ-038 rst_n low during RWAIT: no rsp pulse, oen_n=1 after edge, first post-reset tie grants port 0.
REQ-039 Throughout all scenarios: assertion that wren_n and oen_n never both low and readies never both high.
